local_atmos_light_sequencer: RTL and testbench

//  Frame-level controller for local_atmospheric_light_calculation_alternate (LALC), a free-running 2-stage datapath with no enable.

---
 rtl/local_atmos_light_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_local_atmos_light_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_atmos_light_sequencer.sv
// Frame-level sequencer for the local atmospheric light datapath (LALC).
// Latency: a result is valid 1+LAT cycles after its pixel is accepted; 1 pixel/clk when m_ready holds high.
// Backpressure: s_ready is credit based (FIFO occupancy + in-flight pixels < FIFO_DEPTH), so a stalled m_ready never drops a result.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_wr, a_r/a_g/a_b          write the shadow global A (used from the next commit)
//   start                      begin a frame (only honoured while idle)
//   s_valid/s_ready/s_dark     dark-channel pixel stream in
//   dp_Ar/dp_Ag/dp_Ab          active global A to LALC
//   dp_I_dark                  I_dark to LALC, LAT cycles after acceptance
//   dp_Ar_l/dp_Ag_l/dp_Ab_l    LALC local A results
//   m_valid/m_ready/m_r/m_g/m_b/m_last   result stream out
//   frame_done, busy           frame status
module local_atmos_light_sequencer #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4   // must be >= LAT+1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_wr,
  input  logic [7:0] a_r,
  input  logic [7:0] a_g,
  input  logic [7:0] a_b,
  input  logic       start,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_dark,
  output logic [7:0] dp_Ar,
  output logic [7:0] dp_Ag,
  output logic [7:0] dp_Ab,
  output logic [7:0] dp_I_dark,
  input  logic [7:0] dp_Ar_l,
  input  logic [7:0] dp_Ag_l,
  input  logic [7:0] dp_Ab_l,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_r,
  output logic [7:0] m_g,
  output logic [7:0] m_b,
  output logic       m_last,
  output logic       frame_done,
  output logic       busy
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int IW   = $clog2(LAT + 1);
  localparam int SW   = $clog2(FIFO_DEPTH + LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_A = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t a;
    logic last;
  } res_t;

  state_t          state_q, state_d;
  rgb_t            act_a_q, shd_a_q, wr_a, commit_a;
  logic            a_pending_q;
  logic            commit;
  logic [PCW-1:0]  pix_cnt_q;
  logic            is_last_px;
  logic            accept;
  logic [LAT-1:0]  vld_sr_q;
  logic [LAT-1:0]  last_sr_q;
  logic [7:0]      dly_q [LAT];
  res_t            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   fifo_cnt_q;
  logic [IW-1:0]   inflight;
  logic            credit_ok;
  logic            push, pop;
  res_t            push_dat, head;

  // ---------------------------------------------------------------- global A
  assign wr_a     = {a_r, a_g, a_b};
  // A written in the commit cycle itself wins over the older shadow value.
  assign commit_a = a_wr ? wr_a : shd_a_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_a_q     <= '0;
      act_a_q     <= '0;
      a_pending_q <= 1'b0;
    end else begin
      if (a_wr) shd_a_q <= wr_a;
      if (commit) begin
        act_a_q     <= commit_a;
        a_pending_q <= 1'b0;
      end else if (a_wr) begin
        a_pending_q <= 1'b1;
      end
    end
  end

  // A is constant across a frame, so driving it continuously keeps every
  // LALC pipeline stage coherent regardless of bubbles.
  assign dp_Ar = act_a_q.r;
  assign dp_Ag = act_a_q.g;
  assign dp_Ab = act_a_q.b;

  // ---------------------------------------------------------------- credits
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + IW'(vld_sr_q[i]);
  end

  // Every in-flight pixel already owns a FIFO slot, so the tail push can
  // never find the FIFO full.
  assign credit_ok  = (SW'(fifo_cnt_q) + SW'(inflight)) < SW'(FIFO_DEPTH);
  assign is_last_px = (pix_cnt_q == PCW'(NPIX - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    commit     = 1'b0;
    s_ready    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (a_pending_q || a_wr) begin
            commit  = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_WAIT_A;
          end
        end
      end
      ST_WAIT_A: begin
        if (a_wr) begin
          commit  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_ready = credit_ok;
        if (s_valid && credit_ok && is_last_px) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Empty delay line and FIFO means the tagged last result has left.
        if (vld_sr_q == '0 && fifo_cnt_q == '0) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign accept = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pix_cnt_q <= '0;
    else if (accept) pix_cnt_q <= is_last_px ? '0 : pix_cnt_q + PCW'(1);
  end

  // ---------------------------------------------------------------- delay line
  // Data stages only advance behind a valid bit, so the tail holds the last
  // real pixel through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q  <= '0;
      last_sr_q <= '0;
      for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
    end else begin
      vld_sr_q[0]  <= accept;
      last_sr_q[0] <= accept && is_last_px;
      if (accept) dly_q[0] <= s_dark;
      for (int i = 1; i < LAT; i++) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        last_sr_q[i] <= last_sr_q[i-1];
        if (vld_sr_q[i-1]) dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign dp_I_dark = dly_q[LAT-1];

  // ---------------------------------------------------------------- result FIFO
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push     = vld_sr_q[LAT-1];
  assign push_dat = '{a: '{r: dp_Ar_l, g: dp_Ag_l, b: dp_Ab_l}, last: last_sr_q[LAT-1]};
  assign m_valid  = (fifo_cnt_q != '0);
  assign pop      = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= push_dat;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign head   = fifo_mem[rd_ptr_q];
  assign m_r    = head.a.r;
  assign m_g    = head.a.g;
  assign m_b    = head.a.b;
  assign m_last = head.last && m_valid;

  // A push into a full FIFO without a simultaneous pop would drop a result.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_cnt_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_local_atmos_light_sequencer.sv
// Bench for local_atmos_light_sequencer on a 4x2 frame with a behavioural LALC
// stand-in (A through two register stages, I_dark applied at the output).
// Expected results come from a per-frame A and the LALC rule, held in a scoreboard queue.
module tb_local_atmos_light_sequencer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_wr, start, s_valid, s_ready, m_valid, m_ready, m_last, frame_done, busy;
  logic [7:0] a_r, a_g, a_b, s_dark;
  logic [7:0] dp_Ar, dp_Ag, dp_Ab, dp_I_dark, dp_Ar_l, dp_Ag_l, dp_Ab_l;
  logic [7:0] m_r, m_g, m_b;

  always #5 clk = ~clk;

  local_atmos_light_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_wr(a_wr), .a_r(a_r), .a_g(a_g), .a_b(a_b),
    .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_dark(s_dark),
    .dp_Ar(dp_Ar), .dp_Ag(dp_Ag), .dp_Ab(dp_Ab), .dp_I_dark(dp_I_dark),
    .dp_Ar_l(dp_Ar_l), .dp_Ag_l(dp_Ag_l), .dp_Ab_l(dp_Ab_l),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_r(m_r), .m_g(m_g), .m_b(m_b), .m_last(m_last),
    .frame_done(frame_done), .busy(busy)
  );

  // LALC rule: dark pixels (I_dark < 128) get A*15/16, bright pixels get A.
  function automatic logic [7:0] local_of(input logic [7:0] a, input logic [7:0] d);
    return (d < 8'd128) ? 8'((16'(a) * 16'd15) >> 4) : a;
  endfunction

  logic [23:0] lalc_a1 = '0;
  logic [23:0] lalc_a2 = '0;
  always @(posedge clk) begin
    lalc_a1 <= {dp_Ar, dp_Ag, dp_Ab};
    lalc_a2 <= lalc_a1;
  end
  assign dp_Ar_l = local_of(lalc_a2[23:16], dp_I_dark);
  assign dp_Ag_l = local_of(lalc_a2[15:8],  dp_I_dark);
  assign dp_Ab_l = local_of(lalc_a2[7:0],   dp_I_dark);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic [7:0] r, g, b;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e_in, e_out;
  logic [23:0] frame_a = '0;
  int          acc_cnt = 0;
  int          cyc     = 0;
  bit          lat_chk = 1'b0;
  bit          last_xfer_prev = 1'b0;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_xfer_prev = 1'b0;
    end else begin
      // Outstanding results equal FIFO occupancy plus in-flight pixels.
      if (sb_q.size() >= DEPTH) check_eq("credit_block", s_ready, 1'b0);
      if (s_valid && s_ready) begin
        e_in.r    = local_of(frame_a[23:16], s_dark);
        e_in.g    = local_of(frame_a[15:8],  s_dark);
        e_in.b    = local_of(frame_a[7:0],   s_dark);
        e_in.last = (acc_cnt == NPIX - 1);
        e_in.cyc  = cyc;
        sb_q.push_back(e_in);
        acc_cnt = (acc_cnt == NPIX - 1) ? 0 : acc_cnt + 1;
      end
      if (frame_done || last_xfer_prev) check_eq("frame_done", frame_done, last_xfer_prev);
      last_xfer_prev = 1'b0;
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_result", m_valid, 1'b0);
        end else begin
          e_out = sb_q.pop_front();
          check_eq("m_r", m_r, e_out.r);
          check_eq("m_g", m_g, e_out.g);
          check_eq("m_b", m_b, e_out.b);
          check_eq("m_last", m_last, e_out.last);
          if (lat_chk) check_eq("latency", cyc - e_out.cyc, 1 + LAT);
          last_xfer_prev = e_out.last;
        end
      end
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit wr, input logic [23:0] a);
    a_wr  = wr;
    {a_r, a_g, a_b} = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_wr  = 1'b0;
  endtask

  task automatic write_a(input logic [23:0] a);
    a_wr = 1'b1;
    {a_r, a_g, a_b} = a;
    tick();
    a_wr = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int vld_pct, input bit rnd, input logic [7:0] dark);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 2000) begin
      s_valid = ($urandom_range(0, 99) < vld_pct);
      s_dark  = rnd ? 8'($urandom) : dark;
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      tick();
      guard++;
    end
    s_valid = 1'b0;
    check_eq("send_count", sent, n);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    tick();
    check_eq("done_seen", seen, 1'b1);
    check_eq("idle_after", busy, 1'b0);
    check_eq("sb_empty", sb_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_s_ready"}, s_ready, 1'b0);
    check_eq({tag, "_m_valid"}, m_valid, 1'b0);
    check_eq({tag, "_m_last"}, m_last, 1'b0);
    check_eq({tag, "_frame_done"}, frame_done, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_dp_a"}, {dp_Ar, dp_Ag, dp_Ab}, 24'h0);
    check_eq({tag, "_dp_dark"}, dp_I_dark, 8'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- tests
  initial begin
    rst_n = 1'b0; a_wr = 1'b0; start = 1'b0; s_valid = 1'b0;
    a_r = '0; a_g = '0; a_b = '0; s_dark = '0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: bright pixels pass A through; latency and frame_done timing checked.
    lat_chk = 1'b1;
    frame_a = {8'd180, 8'd200, 8'd200};
    start_frame(1'b1, frame_a);
    send_pixels(NPIX, 100, 1'b0, 8'd200);
    wait_done();

    // 2: dark pixels, A re-written together with start.
    start_frame(1'b1, frame_a);
    send_pixels(NPIX, 100, 1'b0, 8'd50);
    wait_done();

    // 3: start with no pending A waits for a_wr.
    frame_a = {8'd90, 8'd140, 8'd230};
    start_frame(1'b0, 24'h0);
    s_valid = 1'b1;
    s_dark  = 8'd10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("wait_a_busy", busy, 1'b1);
      check_eq("wait_a_ready", s_ready, 1'b0);
      tick();
    end
    s_valid = 1'b0;
    write_a(frame_a);
    send_pixels(NPIX, 100, 1'b1, 8'd0);
    wait_done();

    // 4: downstream stall mid-frame fills exactly the credit window.
    lat_chk = 1'b0;
    frame_a = {8'd60, 8'd70, 8'd250};
    start_frame(1'b1, frame_a);
    send_pixels(2, 100, 1'b1, 8'd0);
    ready_mode = 2;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_dark = 8'($urandom);
      tick();
    end
    @(negedge clk);
    check_eq("stall_fill", sb_q.size(), DEPTH);
    check_eq("stall_ready", s_ready, 1'b0);
    check_eq("stall_head", m_valid, 1'b1);
    tick();
    s_valid = 1'b0;
    ready_mode = 0;
    send_pixels(NPIX - acc_cnt, 100, 1'b1, 8'd0);
    wait_done();

    // 5: a_wr during a frame only affects the next frame.
    lat_chk = 1'b1;
    frame_a = {8'd180, 8'd200, 8'd200};
    start_frame(1'b1, frame_a);
    send_pixels(3, 100, 1'b0, 8'd200);
    write_a({8'd100, 8'd100, 8'd100});
    send_pixels(NPIX - 3, 100, 1'b0, 8'd200);
    wait_done();
    frame_a = {8'd100, 8'd100, 8'd100};
    start_frame(1'b0, 24'h0);
    send_pixels(NPIX, 100, 1'b0, 8'd200);
    wait_done();

    // 6: reset mid-frame clears everything; next frame runs cleanly.
    frame_a = {8'd33, 8'd66, 8'd99};
    start_frame(1'b1, frame_a);
    send_pixels(5, 100, 1'b1, 8'd0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    sb_q.delete();
    acc_cnt = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    frame_a = {8'd210, 8'd20, 8'd128};
    start_frame(1'b1, frame_a);
    send_pixels(NPIX, 100, 1'b1, 8'd0);
    wait_done();

    // Random frames: random A, darks, valid gaps and downstream readiness.
    lat_chk = 1'b0;
    ready_mode = 1;
    for (int f = 0; f < 4; f++) begin
      frame_a = 24'($urandom);
      start_frame(1'b1, frame_a);
      send_pixels(NPIX, 70, 1'b1, 8'd0);
      wait_done();
    end
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
